// File: rtl/axi_frame_reader_if.sv
// AXI4 read-address/read-data channels and the AXI4-Stream video output of the frame reader,
// bundled so the reader and its memory/sink see one port each.
interface axi_frame_reader_if;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
           m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
           m_axis_tready
  );
endinterface

// File: rtl/axi_frame_reader.sv
// Reads one 32-bit-per-pixel frame from DDR with single-outstanding INCR bursts and replays it
// as an AXI4-Stream video stream (tuser = start of frame, tlast = end of line).
module axi_frame_reader #(
  parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          FRAME_WIDTH  = 1920,
  parameter int          FRAME_HEIGHT = 1080,
  parameter int          BURST_LEN    = 16,
  parameter int          FIFO_DEPTH   = 64
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_areset,
  axi_frame_reader_if.master   bus,
  input  logic                 frame_start,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 frame_error
);
  localparam int TOTAL_BURSTS = FRAME_WIDTH * FRAME_HEIGHT / BURST_LEN;
  localparam int BCW = $clog2(TOTAL_BURSTS + 1);
  localparam int BTW = $clog2(BURST_LEN + 1);
  localparam int PTW = $clog2(FIFO_DEPTH);
  localparam int CNW = $clog2(FIFO_DEPTH + 1);
  localparam int XW  = $clog2(FRAME_WIDTH + 1);
  localparam int YW  = $clog2(FRAME_HEIGHT + 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_DRAIN} state_t;

  state_t          state;
  logic [31:0]     araddr_q;
  logic            arvalid_q;
  logic            rready_q;
  logic [BCW-1:0]  burst_cnt;
  logic [BTW-1:0]  beat_cnt;

  logic [23:0]     mem [FIFO_DEPTH];
  logic [PTW-1:0]  wr_ptr, rd_ptr;
  logic [CNW-1:0]  fifo_cnt;
  logic            tvalid_q;
  logic [23:0]     tdata_q;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;

  logic wr_fire, out_free, pix_hs, mem_pop, bypass, mem_push;
  logic space_ok, last_pix, start_acc, last_beat;
  logic [CNW-1:0] occupancy;
  logic unused_rdata_hi;

  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'h2;
  assign bus.m_axi_arburst = 2'h1;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'h2;
  assign bus.m_axi_arprot  = 3'h0;
  assign bus.m_axi_arqos   = 4'h0;
  assign bus.m_axi_rready  = rready_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tuser  = tvalid_q && (x_cnt == '0) && (y_cnt == '0);
  assign bus.m_axis_tlast  = tvalid_q && (x_cnt == XW'(FRAME_WIDTH - 1));
  assign unused_rdata_hi   = ^bus.m_axi_rdata[31:24];

  // The output register counts as one FIFO entry, so "full" means 64 pixels held in total.
  assign wr_fire   = bus.m_axi_rvalid && rready_q;
  assign out_free  = !tvalid_q || bus.m_axis_tready;
  assign pix_hs    = tvalid_q && bus.m_axis_tready;
  assign mem_pop   = (fifo_cnt != '0) && out_free;
  assign bypass    = wr_fire && (fifo_cnt == '0) && out_free;
  assign mem_push  = wr_fire && !bypass;
  assign occupancy = fifo_cnt + CNW'(tvalid_q);
  assign space_ok  = (CNW'(FIFO_DEPTH) - occupancy) >= CNW'(BURST_LEN);
  assign last_pix  = pix_hs && (x_cnt == XW'(FRAME_WIDTH - 1)) && (y_cnt == YW'(FRAME_HEIGHT - 1));
  assign start_acc = (state == S_IDLE) && frame_start && !frame_done;
  assign last_beat = beat_cnt == BTW'(BURST_LEN - 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state       <= S_IDLE;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start_acc) begin
          state       <= S_ADDR;
          arvalid_q   <= 1'b1;
          araddr_q    <= C_M_AXI_TARGET_SLAVE_BASE_ADDR;
          burst_cnt   <= '0;
          frame_busy  <= 1'b1;
          frame_error <= 1'b0;
        end
        S_ADDR: if (bus.m_axi_arready) begin
          state     <= S_DATA;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          araddr_q  <= araddr_q + BURST_BYTES;
          burst_cnt <= burst_cnt + BCW'(1);
          beat_cnt  <= '0;
        end
        S_DATA: if (bus.m_axi_rvalid) begin
          // Our own beat count ends the burst; rlast is only cross-checked against it.
          if (bus.m_axi_rresp != 2'b00 || bus.m_axi_rlast != last_beat) frame_error <= 1'b1;
          if (last_beat) begin
            state    <= S_WAIT;
            rready_q <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + BTW'(1);
          end
        end
        S_WAIT: begin
          if (burst_cnt == BCW'(TOTAL_BURSTS)) begin
            state <= S_DRAIN;
          end else if (space_ok) begin
            state     <= S_ADDR;
            arvalid_q <= 1'b1;
          end
        end
        S_DRAIN: ;
        default: state <= S_IDLE;
      endcase
      // The final pixel can leave while still in WAIT when the last beat bypasses the FIFO.
      if (last_pix) begin
        state      <= S_IDLE;
        frame_busy <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

  // NOTE: the pixel storage has no reset; clearing pointers and count empties the FIFO.
  always_ff @(posedge m_axi_aclk) begin
    if (mem_push) mem[wr_ptr] <= bus.m_axi_rdata[23:0];
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      if (mem_push) wr_ptr <= wr_ptr + PTW'(1);
      if (mem_pop)  rd_ptr <= rd_ptr + PTW'(1);
      if (mem_push && !mem_pop)      fifo_cnt <= fifo_cnt + CNW'(1);
      else if (mem_pop && !mem_push) fifo_cnt <= fifo_cnt - CNW'(1);

      if (mem_pop) begin
        tdata_q  <= mem[rd_ptr];
        tvalid_q <= 1'b1;
      end else if (bypass) begin
        tdata_q  <= bus.m_axi_rdata[23:0];
        tvalid_q <= 1'b1;
      end else if (pix_hs) begin
        tvalid_q <= 1'b0;
      end

      if (start_acc) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pix_hs) begin
        if (x_cnt == XW'(FRAME_WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == YW'(FRAME_HEIGHT - 1)) ? '0 : y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
    end
  end
endmodule
